clock_monitor_multi: RTL and testbench

Multi-channel, synthesizable clock-activity monitor. Each of `NUM_CH` asynchronous monitored clocks is sampled in the `ref_clk` domain. The block measures the number of `ref_clk` cycles between successive toggles of each clock and classifies every channel as healthy, too fast (glitch), or too slow/halted. It extends the single-channel display-only checker with:

- real reset
- a 2+ stage synchronizer
- halt detection without waiting for an edge
- a qualification state machine
- sticky error flags
- an interrupt output

---
 rtl/clock_monitor_pkg.sv | 16 +
 rtl/clock_monitor_channel.sv | 133 +++++++++++++
 rtl/clock_monitor_multi.sv | 65 ++++++
 tb/tb_clock_monitor_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types for the multi-channel clock-activity monitor.
//   mon_state_e : per-channel qualification state, 3-bit encoding
//   STATE_W     : width of one channel's state field
package clock_monitor_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StInit  = 3'd0,
    StCheck = 3'd1,
    StOk    = 3'd2,
    StFast  = 3'd3,
    StSlow  = 3'd4
  } mon_state_e;

endpackage

// File: rtl/clock_monitor_channel.sv
// One monitored-clock channel: synchronizer, toggle-interval counter,
// qualification FSM and sticky error flags. All logic is in the i_clk domain.
//   i_clk      : reference (sampling) clock
//   i_rst      : asynchronous active-high reset
//   i_mon_clk  : monitored clock, asynchronous to i_clk
//   i_en       : channel enable, 0 holds the channel in StInit
//   i_clr      : write-1-to-clear for the sticky flags (a same-cycle set wins)
//   o_ok       : registered, state == StOk
//   o_err_fast : sticky, set on a too-short toggle interval
//   o_err_slow : sticky, set on a timeout
//   o_state    : registered state code
module clock_monitor_channel
  import clock_monitor_pkg::*;
#(
  parameter int unsigned MIN_WAIT    = 3,
  parameter int unsigned MAX_WAIT    = 50,
  parameter int unsigned GOOD_EDGES  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mon_clk,
  input  logic               i_en,
  input  logic               i_clr,
  output logic               o_ok,
  output logic               o_err_fast,
  output logic               o_err_slow,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned GOOD_W = $clog2(GOOD_EDGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_WAIT);
  // Interval I = cnt + 1, so I < MIN_WAIT is the same as cnt < MIN_WAIT - 1.
  localparam logic [CNT_W-1:0]  CNT_FAST = CNT_W'(MIN_WAIT - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_EDGES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_p;
  logic [CNT_W-1:0]       r_cnt;
  logic [GOOD_W-1:0]      r_good;
  mon_state_e             r_state;
  logic                   r_ok;
  logic                   r_err_fast;
  logic                   r_err_slow;

  logic                   w_s;
  logic                   w_toggle;
  logic                   w_cnt_max;
  logic [CNT_W-1:0]       w_cnt_d;
  logic [GOOD_W-1:0]      w_good_d;
  logic [GOOD_W-1:0]      w_good_inc;
  mon_state_e             w_state_d;
  logic                   w_set_fast;
  logic                   w_set_slow;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_toggle   = w_s ^ r_p;
  assign w_cnt_max  = (r_cnt == CNT_MAX);
  assign w_good_inc = (r_good == GOOD_MAX) ? r_good : r_good + GOOD_W'(1);

  // Synchronizer plus history flop. The history flop always follows s, which
  // also covers the disabled case: no toggle is reported on the enable cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_p    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_mon_clk};
      r_p    <= w_s;
    end
  end

  always_comb begin
    w_cnt_d    = r_cnt;
    w_good_d   = r_good;
    w_state_d  = r_state;
    w_set_fast = 1'b0;
    w_set_slow = 1'b0;

    if (!i_en || w_toggle) begin
      w_cnt_d = '0;
    end else if (!w_cnt_max) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end

    if (!i_en) begin
      w_state_d = StInit;
      w_good_d  = '0;
    end else if (!w_toggle && w_cnt_max && (r_state != StSlow)) begin
      w_state_d  = StSlow;
      w_good_d   = '0;
      w_set_slow = 1'b1;
    end else if (w_toggle) begin
      if (r_state == StInit || w_cnt_max) begin
        // First interval after INIT, or an edge after a timeout: unmeasured.
        w_state_d = StCheck;
        w_good_d  = '0;
      end else if (r_cnt < CNT_FAST) begin
        w_state_d  = StFast;
        w_good_d   = '0;
        w_set_fast = 1'b1;
      end else begin
        w_good_d  = w_good_inc;
        w_state_d = (r_state == StOk || w_good_inc == GOOD_MAX) ? StOk : StCheck;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_good     <= '0;
      r_state    <= StInit;
      r_ok       <= 1'b0;
      r_err_fast <= 1'b0;
      r_err_slow <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_good     <= w_good_d;
      r_state    <= w_state_d;
      r_ok       <= (w_state_d == StOk);
      r_err_fast <= w_set_fast | (r_err_fast & ~i_clr);
      r_err_slow <= w_set_slow | (r_err_slow & ~i_clr);
    end
  end

  assign o_ok       = r_ok;
  assign o_err_fast = r_err_fast;
  assign o_err_slow = r_err_slow;
  assign o_state    = r_state;

endmodule

// File: rtl/clock_monitor_multi.sv
// Multi-channel clock-activity monitor: NUM_CH independent channels sampled in
// the ref_clk domain, plus a registered interrupt.
//   ref_clk  : sampling clock
//   rst      : asynchronous active-high reset
//   mon_clk  : monitored clocks
//   ch_en    : per-channel enable
//   err_clr  : per-channel write-1-to-clear of sticky flags
//   ch_ok    : per-channel state == OK
//   err_fast : per-channel sticky too-fast flag
//   err_slow : per-channel sticky timeout flag
//   ch_state : channel i state in bits [3i+2:3i]
//   irq      : OR of all error flags, one cycle behind them
module clock_monitor_multi
  import clock_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MIN_WAIT    = 3,
  parameter int unsigned MAX_WAIT    = 50,
  parameter int unsigned GOOD_EDGES  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      ref_clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         mon_clk,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         err_clr,
  output logic [NUM_CH-1:0]         ch_ok,
  output logic [NUM_CH-1:0]         err_fast,
  output logic [NUM_CH-1:0]         err_slow,
  output logic [STATE_W*NUM_CH-1:0] ch_state,
  output logic                      irq
);

  logic r_irq;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_monitor_channel #(
      .MIN_WAIT    (MIN_WAIT),
      .MAX_WAIT    (MAX_WAIT),
      .GOOD_EDGES  (GOOD_EDGES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_channel (
      .i_clk      (ref_clk),
      .i_rst      (rst),
      .i_mon_clk  (mon_clk[g]),
      .i_en       (ch_en[g]),
      .i_clr      (err_clr[g]),
      .o_ok       (ch_ok[g]),
      .o_err_fast (err_fast[g]),
      .o_err_slow (err_slow[g]),
      .o_state    (ch_state[STATE_W*g +: STATE_W])
    );
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |{err_fast, err_slow};
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_clock_monitor_multi.sv
module tb_clock_monitor_multi;
  import clock_monitor_pkg::*;

  logic       ref_clk;
  logic       rst;
  logic [1:0] mon_clk;
  logic [1:0] ch_en;
  logic [1:0] err_clr;
  logic [1:0] ch_ok;
  logic [1:0] err_fast;
  logic [1:0] err_slow;
  logic [5:0] ch_state;
  logic       irq;

  int n_cmp;
  int n_fail;
  int cyc;
  int hp[2];
  int ph[2];

  clock_monitor_multi #(
    .NUM_CH      (2),
    .MIN_WAIT    (3),
    .MAX_WAIT    (50),
    .GOOD_EDGES  (4),
    .SYNC_STAGES (2)
  ) dut (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .mon_clk  (mon_clk),
    .ch_en    (ch_en),
    .err_clr  (err_clr),
    .ch_ok    (ch_ok),
    .err_fast (err_fast),
    .err_slow (err_slow),
    .ch_state (ch_state),
    .irq      (irq)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // One ref_clk edge, sample point 1 time unit later, then advance the
  // monitored clocks (half-period hp, 0 = stopped).
  task automatic step();
    @(posedge ref_clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (hp[i] != 0) begin
        ph[i]++;
        if (ph[i] >= hp[i]) begin
          ph[i] = 0;
          mon_clk[i] = ~mon_clk[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = 2'b00; err_clr = 2'b00; mon_clk = 2'b00;
    hp[0] = 0; hp[1] = 0; ph[0] = 0; ph[1] = 0; cyc = 0;
    repeat (3) @(posedge ref_clk);
    #1;
    n_cmp++; if (ch_state !== 6'd0) begin n_fail++; $display("FAIL reset_state: got %0h want 0", ch_state); end
    n_cmp++; if ({ch_ok, err_fast, err_slow, irq} !== 7'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h want 0", {ch_ok, err_fast, err_slow, irq});
    end
    #3 rst = 1'b0;
  endtask

  // ch0 half-period 10, ch1 half-period 7; cyc counts edges after enable.
  task automatic test_bringup();
    ch_en = 2'b11; hp[0] = 10; hp[1] = 7; ph[0] = 0; ph[1] = 0; cyc = 0;
    while (cyc < 53) begin
      step();
      if (cyc == 12) begin
        n_cmp++; if (ch_state[2:0] !== StInit) begin n_fail++; $display("FAIL t1_init_c12: got %0d want %0d", ch_state[2:0], StInit); end
      end
      if (cyc == 13) begin
        n_cmp++; if (ch_state[2:0] !== StCheck) begin n_fail++; $display("FAIL t1_check_c13: got %0d want %0d", ch_state[2:0], StCheck); end
      end
      if (cyc == 52) begin
        n_cmp++; if (ch_state[2:0] !== StCheck) begin n_fail++; $display("FAIL t1_check_c52: got %0d want %0d", ch_state[2:0], StCheck); end
      end
      if (cyc == 53) begin
        n_cmp++; if (ch_state[2:0] !== StOk) begin n_fail++; $display("FAIL t1_ok_c53: got %0d want %0d", ch_state[2:0], StOk); end
        n_cmp++; if (ch_ok !== 2'b11) begin n_fail++; $display("FAIL t1_ch_ok: got %b want 11", ch_ok); end
        n_cmp++; if ({err_fast, err_slow, irq} !== 5'd0) begin n_fail++; $display("FAIL t1_no_flags: got %b want 0", {err_fast, err_slow, irq}); end
      end
    end
  endtask

  task automatic test_glitch();
    while (cyc < 93) begin
      step();
      if (cyc == 55 || cyc == 56) mon_clk[0] = ~mon_clk[0];
      if (cyc == 58) begin
        n_cmp++; if (ch_state[2:0] !== StOk) begin n_fail++; $display("FAIL t2_ok_c58: got %0d want %0d", ch_state[2:0], StOk); end
      end
      if (cyc == 59) begin
        n_cmp++; if (ch_state[2:0] !== StFast) begin n_fail++; $display("FAIL t2_fast: got %0d want %0d", ch_state[2:0], StFast); end
        n_cmp++; if (err_fast[0] !== 1'b1) begin n_fail++; $display("FAIL t2_err_fast: got %b want 1", err_fast[0]); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t2_irq_lag: got %b want 0", irq); end
      end
      if (cyc == 60) begin
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t2_irq: got %b want 1", irq); end
      end
      if (cyc == 63) begin
        n_cmp++; if (ch_state[2:0] !== StCheck) begin n_fail++; $display("FAIL t2_check_c63: got %0d want %0d", ch_state[2:0], StCheck); end
      end
      if (cyc == 92) begin
        n_cmp++; if (ch_state[2:0] !== StCheck) begin n_fail++; $display("FAIL t2_check_c92: got %0d want %0d", ch_state[2:0], StCheck); end
      end
      if (cyc == 93) begin
        n_cmp++; if (ch_state[2:0] !== StOk) begin n_fail++; $display("FAIL t2_reok: got %0d want %0d", ch_state[2:0], StOk); end
        n_cmp++; if (err_fast[0] !== 1'b1) begin n_fail++; $display("FAIL t2_sticky: got %b want 1", err_fast[0]); end
      end
    end
  endtask

  // ch1 last toggle at cyc 91 is seen at edge 94, so SLOW lands on edge 145.
  task automatic test_halt();
    hp[1] = 0;
    while (cyc < 188) begin
      step();
      if (cyc == 150) begin hp[1] = 7; ph[1] = 0; end
      if (cyc == 144) begin
        n_cmp++; if (ch_state[5:3] !== StOk) begin n_fail++; $display("FAIL t3_ok_c144: got %0d want %0d", ch_state[5:3], StOk); end
        n_cmp++; if (err_slow[1] !== 1'b0) begin n_fail++; $display("FAIL t3_noslow_c144: got %b want 0", err_slow[1]); end
      end
      if (cyc == 145) begin
        n_cmp++; if (ch_state[5:3] !== StSlow) begin n_fail++; $display("FAIL t3_slow: got %0d want %0d", ch_state[5:3], StSlow); end
        n_cmp++; if ({err_slow[1], ch_ok[1]} !== 2'b10) begin n_fail++; $display("FAIL t3_slow_flag: got %b want 10", {err_slow[1], ch_ok[1]}); end
      end
      if (cyc == 159) begin
        n_cmp++; if (ch_state[5:3] !== StSlow) begin n_fail++; $display("FAIL t3_slow_c159: got %0d want %0d", ch_state[5:3], StSlow); end
      end
      if (cyc == 160) begin
        n_cmp++; if (ch_state[5:3] !== StCheck) begin n_fail++; $display("FAIL t3_restart: got %0d want %0d", ch_state[5:3], StCheck); end
      end
      if (cyc == 187) begin
        n_cmp++; if (ch_state[5:3] !== StCheck) begin n_fail++; $display("FAIL t3_check_c187: got %0d want %0d", ch_state[5:3], StCheck); end
      end
      if (cyc == 188) begin
        n_cmp++; if (ch_state[5:3] !== StOk) begin n_fail++; $display("FAIL t3_reok: got %0d want %0d", ch_state[5:3], StOk); end
        n_cmp++; if (err_slow[1] !== 1'b1) begin n_fail++; $display("FAIL t3_sticky: got %b want 1", err_slow[1]); end
      end
    end
  endtask

  task automatic test_clear();
    err_clr[0] = 1'b1;
    while (cyc < 203) begin
      step();
      if (cyc == 189) begin
        n_cmp++; if (err_fast[0] !== 1'b0) begin n_fail++; $display("FAIL t4_clr_fast: got %b want 0", err_fast[0]); end
        err_clr[0] = 1'b0;
      end
      if (cyc == 195 || cyc == 196) mon_clk[0] = ~mon_clk[0];
      if (cyc == 198) err_clr[0] = 1'b1;
      if (cyc == 199) begin
        n_cmp++; if (ch_state[2:0] !== StFast) begin n_fail++; $display("FAIL t4_fast: got %0d want %0d", ch_state[2:0], StFast); end
        n_cmp++; if (err_fast[0] !== 1'b1) begin n_fail++; $display("FAIL t4_set_wins: got %b want 1", err_fast[0]); end
        err_clr[0] = 1'b0;
      end
      if (cyc == 201) err_clr[1] = 1'b1;
      if (cyc == 202) begin
        n_cmp++; if (err_slow !== 2'b00) begin n_fail++; $display("FAIL t4_clr_slow: got %b want 00", err_slow); end
        n_cmp++; if (err_fast[0] !== 1'b1) begin n_fail++; $display("FAIL t4_clr_isolated: got %b want 1", err_fast[0]); end
        err_clr[1] = 1'b0;
      end
    end
  endtask

  task automatic test_disable();
    while (cyc < 280) begin
      step();
      if (cyc == 235 || cyc == 236) mon_clk[0] = ~mon_clk[0];
      if (cyc == 273) begin
        n_cmp++; if (ch_state[2:0] !== StOk) begin n_fail++; $display("FAIL t5_ok_c273: got %0d want %0d", ch_state[2:0], StOk); end
      end
      if (cyc == 275) ch_en[0] = 1'b0;
      if (cyc == 276) begin
        n_cmp++; if (ch_state[2:0] !== StInit) begin n_fail++; $display("FAIL t5_init: got %0d want %0d", ch_state[2:0], StInit); end
        n_cmp++; if ({ch_ok[0], err_fast[0]} !== 2'b01) begin n_fail++; $display("FAIL t5_flags_kept: got %b want 01", {ch_ok[0], err_fast[0]}); end
        n_cmp++; if (ch_state[5:3] !== StOk) begin n_fail++; $display("FAIL t5_ch1_indep: got %0d want %0d", ch_state[5:3], StOk); end
      end
      if (cyc == 280) begin
        n_cmp++; if (ch_state[2:0] !== StInit) begin n_fail++; $display("FAIL t5_held: got %0d want %0d", ch_state[2:0], StInit); end
      end
    end
  endtask

  task automatic test_async_reset();
    step();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t6_irq_before: got %b want 1", irq); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (ch_state !== 6'd0) begin n_fail++; $display("FAIL t6_state: got %0h want 0", ch_state); end
    n_cmp++; if ({ch_ok, err_fast, err_slow, irq} !== 7'd0) begin
      n_fail++; $display("FAIL t6_outputs: got %0h want 0", {ch_ok, err_fast, err_slow, irq});
    end
    repeat (2) @(posedge ref_clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_bringup();
    test_glitch();
    test_halt();
    test_clear();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
